// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed fetch port with an in-order response queue,
// a program port for loading the array, and a flush that drops in-flight fetches.
module imem_responder #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } rsp_t;

  logic [31:0]   mem_q  [DEPTH];
  rsp_t          fifo_q [QDEPTH];

  logic [CW-1:0] count_q,  count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic          push_c;
  logic          pop_c;
  logic          fetch_in_range_c;
  logic          prog_in_range_c;
  rsp_t          fetch_c;
  rsp_t          head_c;

  // Ready depends only on occupancy, flush and reset, never on the consumer side.
  assign req_ready = reset && (count_q < CW'(QDEPTH)) && !flush;
  assign rsp_valid = (count_q != '0);

  always_comb begin
    head_c    = fifo_q[rd_ptr_q];
    rsp_inst  = rsp_valid ? head_c.inst : 32'h0;
    rsp_err   = rsp_valid ? head_c.err  : 1'b0;
  end

  // Fetch lookup; out-of-range addresses never touch the array.
  always_comb begin
    fetch_in_range_c = (req_addr < 32'(DEPTH));
    prog_in_range_c  = (prog_addr < 32'(DEPTH));
    fetch_c.err      = !fetch_in_range_c;
    fetch_c.inst     = fetch_in_range_c ? mem_q[req_addr[AW-1:0]] : 32'h0;
  end

  // Queue bookkeeping; flush overrides both push and pop.
  always_comb begin
    push_c   = req_valid && req_ready;
    pop_c    = rsp_valid && rsp_ready && !flush;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Queue storage; the array read above sees the pre-write word (read-before-write).
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= fetch_c;
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we && prog_in_range_c) mem_q[prog_addr[AW-1:0]] <= prog_data;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: driver pushes hand-computed expected responses,
// an independent monitor pops and compares whenever the DUT hands a word over.
module tb_imem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        flush;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   lat_mode = 0;

  imem_responder #(.DEPTH(256), .QDEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handover is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1 && flush === 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got inst=%h err=%b expected no response", rsp_inst, rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_inst", rsp_inst, e.inst);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd1);
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic step(input logic v, input logic [31:0] a, input logic rr, input logic fl,
                      input logic exp_rdy, input logic [31:0] ei, input logic ee);
    exp_t e;
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    flush     = fl;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (req_valid && req_ready) begin
      e.inst = ei;
      e.err  = ee;
      e.cyc  = cyc;
      e.lat  = lat_mode;
      sb.push_back(e);
    end
    if (fl) sb.delete();
    @(posedge clk);
    #1;
    prog_we   = 1'b0;
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; flush = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    @(posedge clk); #1;

    // Load array while reset is held.
    prog(32'd0, 32'h11111111); step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    prog(32'd1, 32'h22222222); step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    prog(32'd2, 32'h33333333); step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    prog(32'd3, 32'h44444444); step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_inst", rsp_inst, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;

    // Back-to-back fetch with one-cycle latency.
    lat_mode = 1'b1;
    step(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0);
    step(1'b1, 32'd1, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0);
    step(1'b1, 32'd2, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b0);
    step(1'b1, 32'd3, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b0);
    drain();
    lat_mode = 1'b0;

    // Backpressure: queue fills at two entries.
    step(1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0);
    step(1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0);
    step(1'b1, 32'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'd2, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b0);
    drain();

    // Out-of-range fetches.
    step(1'b1, 32'd256,       1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    step(1'b1, 32'hFFFFFFFF,  1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    step(1'b1, 32'd1,         1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0);
    drain();

    // Flush with a full queue and a same-cycle request.
    step(1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0);
    step(1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0);
    step(1'b1, 32'd3, 1'b1, 1'b1, 1'b0, 32'h44444444, 1'b0);
    check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    // Flush with one entry queued: ready must still drop.
    step(1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0);
    step(1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 32'h44444444, 1'b0);
    check("flush2_rsp_valid", 32'(rsp_valid), 32'd0);
    step(1'b1, 32'd2, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b0);
    drain();

    // Read-before-write on the same address.
    prog(32'd2, 32'hDEADBEEF);
    step(1'b1, 32'd2, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b0);
    step(1'b1, 32'd2, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    drain();
    // Out-of-range program write must be ignored.
    prog(32'd256, 32'hBAD0BAD0);
    step(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0);
    drain();

    // Asynchronous reset mid-stream with two entries queued.
    step(1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0);
    step(1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0);
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd0);
    check("async_rst_rsp_inst", rsp_inst, 32'h0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    step(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
